pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/Mem, Mem/WB regs).
//  Detects load-use hazards, branch/jump redirects resolved in MEM, and multi-cycle data-memory waits.
//  Drives every pipeline-register enable and every bubble/flush (valid-clear) strobe, plus the PC enable.
//  Keeps a saturating stall-cycle count and a sticky memory-timeout flag.
// PARAMETERS
//  CNT_W        16   width of stall_cnt_Hzd
//  LU_CYCLES    1    bubbles inserted per load-use hazard (1..7)
//  MEM_TIMEOUT  255  MEM_WAIT cycles before mem_err_Hzd sets (1..2^10-1)
// PORTS
//  clk_Hzd        in   1      single clock, all logic on posedge
//  rst_n_Hzd      in   1      synchronous, active-low reset
//  IDEX_MemRead   in   1      instruction in EX is a load
//  IDEX_Rd        in   5      destination reg of EX instruction
//  IFID_Rs1       in   5      rs1 of ID instruction
//  IFID_Rs2       in   5      rs2 of ID instruction
//  IFID_Rs1_used  in   1      ID instruction reads rs1
//  IFID_Rs2_used  in   1      ID instruction reads rs2
//  EXMem_valid    in   1      MEM-stage instruction is valid
//  EXMem_taken    in   1      MEM-stage branch/jump resolved taken (qualified by EXMem_valid)
//  mem_req        in   1      MEM stage issues a data-memory access
//  mem_ready      in   1      data memory completes access this cycle
//  PC_en          out  1      PC update enable
//  IFID_en/IDEX_en/EXMem_en/MemWB_en  out 1 each  pipeline-register enables
//  IFID_flush/IDEX_flush/EXMem_flush  out 1 each  force valid_in=0 (bubble) into that register
//  stall_cnt_Hzd  out  CNT_W  cycles with PC_en=0, saturating
//  mem_err_Hzd    out  1      sticky: MEM_WAIT exceeded MEM_TIMEOUT
// BEHAVIOUR
//  - Reset (rst_n_Hzd=0 at posedge): state<=RUN, lu_cnt<=0, wait_cnt<=0, stall_cnt<=0, mem_err<=0.
//    While rst_n_Hzd=0 outputs forced: all *_en=1, all *_flush=1, PC_en=1. Reset mid-stall aborts.
//  - Control outputs are combinational from state + inputs (zero-latency); counters/state registered.
//  - lu_hz = IDEX_MemRead & (IDEX_Rd!=0) & ((IFID_Rs1_used&Rs1==Rd)|(IFID_Rs2_used&Rs2==Rd)).
//  - redir = EXMem_valid & EXMem_taken.  mwait = mem_req & ~mem_ready.
//  - Priority per cycle: mwait > redir > lu_hz.
//  - States: RUN, LU_STALL, MEM_WAIT.
//  - RUN, mwait: all en=0, no flush, PC_en=0; ->MEM_WAIT, wait_cnt<=1.
//  - RUN, redir: all en=1, PC_en=1 (loads target), IFID/IDEX/EXMem_flush=1; stay RUN; pending lu dropped.
//  - RUN, lu_hz: PC_en=0, IFID_en=0, IDEX_flush=1, others en=1; if LU_CYCLES>1 ->LU_STALL, lu_cnt<=LU_CYCLES-1.
//  - RUN, none: all en=1, no flush.
//  - LU_STALL: same outputs as RUN lu_hz; lu_cnt-- ; lu_cnt==1 ->RUN. mwait/redir preempt as in RUN
//    (redir ->RUN with flush; mwait ->MEM_WAIT, lu stall remainder discarded).
//  - MEM_WAIT: mem_ready=0: all en=0, PC_en=0, wait_cnt++ (saturating); wait_cnt==MEM_TIMEOUT sets mem_err.
//    mem_ready=1: exit cycle behaves exactly as RUN with mwait=0 (redir/lu_hz evaluated that cycle); ->RUN or LU_STALL.
//  - mem_req dropping while in MEM_WAIT treated as mem_ready=1.
//  - mem_err sticky until reset; does not alter sequencing.
//  - stall_cnt increments each non-reset cycle with PC_en=0; holds at 2^CNT_W-1.
// TESTING
//  1 Reset: hold rst_n_Hzd=0 3 cycles -> all en=1, all flush=1, stall_cnt=0, mem_err=0.
//  2 Load-use: IDEX_MemRead=1,IDEX_Rd=5,IFID_Rs2=5,Rs2_used=1 one cycle -> PC_en=0,IFID_en=0,IDEX_flush=1; stall_cnt=1.
//  3 Rd=x0: same as 2 but IDEX_Rd=0 -> no stall, all en=1.
//  4 Redirect+load-use same cycle: EXMem_valid=1,taken=1 with lu_hz -> PC_en=1, three flushes=1, stall_cnt unchanged.
//  5 Mem wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> all en=0 4 cycles, stall_cnt=4, exit cycle all en=1.
//  6 Timeout: MEM_TIMEOUT=8, mem_ready=0 for 10 cycles -> mem_err=1 after 8th wait cycle, stays 1 after mem_ready.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-resolved redirects and
// data-memory wait stalls, plus a saturating stall-cycle counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LU_CYCLES   = 1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk_Hzd,
  input  logic             rst_n_Hzd,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rd,
  input  logic [4:0]       IFID_Rs1,
  input  logic [4:0]       IFID_Rs2,
  input  logic             IFID_Rs1_used,
  input  logic             IFID_Rs2_used,
  input  logic             EXMem_valid,
  input  logic             EXMem_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMem_en,
  output logic             MemWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMem_flush,
  output logic [CNT_W-1:0] stall_cnt_Hzd,
  output logic             mem_err_Hzd
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);
  localparam logic [9:0] TIMEOUT = 10'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [9:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic lu_hz, redir, mwait;

  assign lu_hz = IDEX_MemRead && (IDEX_Rd != 5'd0) &&
                 ((IFID_Rs1_used && (IFID_Rs1 == IDEX_Rd)) ||
                  (IFID_Rs2_used && (IFID_Rs2 == IDEX_Rd)));
  assign redir = EXMem_valid && EXMem_taken;
  // A dropped mem_req ends a wait just like mem_ready, so one term covers both states.
  assign mwait = mem_req && !mem_ready;

  always_comb begin
    PC_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMem_en    = 1'b1;
    MemWB_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMem_flush = 1'b0;
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;

    if (!rst_n_Hzd) begin
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMem_flush = 1'b1;
    end else if (mwait) begin
      PC_en    = 1'b0;
      IFID_en  = 1'b0;
      IDEX_en  = 1'b0;
      EXMem_en = 1'b0;
      MemWB_en = 1'b0;
      state_d  = MEM_WAIT;
      lu_cnt_d = 3'd0;
      if (state_q != MEM_WAIT) begin
        wait_cnt_d = 10'd1;
      end else if (wait_cnt_q != 10'h3FF) begin
        wait_cnt_d = wait_cnt_q + 10'd1;
      end
      if (wait_cnt_d == TIMEOUT) begin
        mem_err_d = 1'b1;
      end
    end else begin
      wait_cnt_d = 10'd0;
      if (redir) begin
        IFID_flush  = 1'b1;
        IDEX_flush  = 1'b1;
        EXMem_flush = 1'b1;
        state_d     = RUN;
        lu_cnt_d    = 3'd0;
      end else if (lu_hz || (state_q == LU_STALL)) begin
        PC_en      = 1'b0;
        IFID_en    = 1'b0;
        IDEX_flush = 1'b1;
        if (state_q == LU_STALL) begin
          if (lu_cnt_q <= 3'd1) begin
            state_d  = RUN;
            lu_cnt_d = 3'd0;
          end else begin
            lu_cnt_d = lu_cnt_q - 3'd1;
          end
        end else if (LU_CYCLES > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_INIT;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (!PC_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_Hzd) begin
    if (!rst_n_Hzd) begin
      state_q     <= RUN;
      lu_cnt_q    <= 3'd0;
      wait_cnt_q  <= 10'd0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall_cnt_Hzd = stall_cnt_q;
  assign mem_err_Hzd   = mem_err_q;

endmodule
